// File: rtl/alu_seq_pkg.sv
// Shared types and helpers for the byte-serial adder sequencer.
package alu_seq_pkg;

  localparam int unsigned SLICE_W = 8;
  localparam int unsigned SUM_W   = 9;
  localparam int unsigned SEL_W   = 64;
  localparam int unsigned IDX_W   = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Returns byte idx of vec; operands up to SEL_W bits are zero-extended by the caller.
  function automatic logic [SLICE_W-1:0] byte_sel(input logic [SEL_W-1:0] vec,
                                                  input logic [IDX_W-1:0] idx);
    return vec[32'(idx) * SLICE_W +: SLICE_W];
  endfunction

endpackage

// File: rtl/alu_seq_flags.sv
// Zero and signed-overflow flags for the assembled result.
module alu_seq_flags #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] result_i,
  input  logic             a_msb_i,
  input  logic             b_msb_i,
  output logic             zero_c_o,
  output logic             ovf_c_o
);

  always_comb begin
    zero_c_o = ~|result_i;
    ovf_c_o  = (a_msb_i == b_msb_i) && (result_i[WIDTH-1] != a_msb_i);
  end

endmodule

// File: rtl/alu_byte_serial_adder.sv
// Sequences a WIDTH-bit add/sub through an external 8-bit adder slice, one byte per cycle.
// Optional macro ALU_BYTE_SERIAL_ADC_EN adds cin_use for add-with-carry chains.
module alu_byte_serial_adder
  import alu_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SLICE = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
`ifdef ALU_BYTE_SERIAL_ADC_EN
  input  logic             cin_use,
`endif
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow,
  output logic             zero,
  output logic [SUM_W-1:0] add_a,
  output logic [SUM_W-1:0] add_b,
  output logic             add_ci,
  input  logic [SUM_W-1:0] add_sum
);

  localparam int unsigned NSTEP  = WIDTH / SLICE;
  localparam int unsigned STEP_W = (NSTEP > 1) ? $clog2(NSTEP) : 1;
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(NSTEP - 1);

  state_e state_q, state_d;

  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic [WIDTH-1:0]  result_q, result_d;
  logic [WIDTH-1:0]  result_step;
  logic [STEP_W-1:0] step_q, step_d;
  logic              carry_q, carry_d;
  logic              cout_q, cout_d;
  logic              ovf_q, ovf_d;
  logic              zero_q, zero_d;
  logic              init_carry;
  logic              accept;
  logic              last_step;
  logic              zero_c, ovf_c;

  assign accept    = (state_q == IDLE) && start;
  assign last_step = (step_q == LAST_STEP);

  // Seed carry: subtract supplies the +1 of two's complement, ADC reuses the last carry.
  always_comb begin
`ifdef ALU_BYTE_SERIAL_ADC_EN
    init_carry = cin_use ? cout_q : sub;
`else
    init_carry = sub;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last_step) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy   = 1'b0;
    done   = 1'b0;
    add_a  = '0;
    add_b  = '0;
    add_ci = 1'b0;
    case (state_q)
      RUN: begin
        busy   = 1'b1;
        add_a  = {1'b0, byte_sel(SEL_W'(a_q), IDX_W'(step_q))};
        add_b  = {1'b0, byte_sel(SEL_W'(b_q), IDX_W'(step_q))};
        add_ci = carry_q;
      end
      DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
  end

  // Result with the current step's byte merged in; flags see the final value on the DONE entry edge.
  always_comb begin
    result_step = result_q;
    result_step[32'(step_q) * SLICE_W +: SLICE_W] = add_sum[SLICE_W-1:0];
  end

  alu_seq_flags #(.WIDTH(WIDTH)) u_flags (
    .result_i (result_step),
    .a_msb_i  (a_q[WIDTH-1]),
    .b_msb_i  (b_q[WIDTH-1]),
    .zero_c_o (zero_c),
    .ovf_c_o  (ovf_c)
  );

  always_comb begin
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    step_d   = step_q;
    carry_d  = carry_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    zero_d   = zero_q;
    if (accept) begin
      a_d     = op_a;
      b_d     = sub ? ~op_b : op_b;
      carry_d = init_carry;
      step_d  = '0;
    end else if (state_q == RUN) begin
      result_d = result_step;
      carry_d  = add_sum[SLICE_W];
      step_d   = step_q + 1'b1;
      if (last_step) begin
        cout_d = add_sum[SLICE_W];
        ovf_d  = ovf_c;
        zero_d = zero_c;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      step_q   <= '0;
      carry_q  <= 1'b0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      step_q   <= step_d;
      carry_q  <= carry_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
      zero_q   <= zero_d;
    end
  end

  assign result    = result_q;
  assign carry_out = cout_q;
  assign overflow  = ovf_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_alu_byte_serial_adder.sv
// Directed bench for alu_byte_serial_adder with a behavioural 9-bit adder slice.
module tb_alu_byte_serial_adder;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        sub;
  logic        cin_use;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        carry_out;
  logic        overflow;
  logic        zero;
  logic [8:0]  add_a;
  logic [8:0]  add_b;
  logic        add_ci;
  logic [8:0]  add_sum;

  int errors = 0;
  int checks = 0;

  alu_byte_serial_adder dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .sub       (sub),
`ifdef ALU_BYTE_SERIAL_ADC_EN
    .cin_use   (cin_use),
`endif
    .op_a      (op_a),
    .op_b      (op_b),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .carry_out (carry_out),
    .overflow  (overflow),
    .zero      (zero),
    .add_a     (add_a),
    .add_b     (add_b),
    .add_ci    (add_ci),
    .add_sum   (add_sum)
  );

  assign add_sum = add_a + add_b + 9'(add_ci);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        s;
    logic [31:0] res;
    logic        co;
    logic        ov;
    logic        z;
    logic [3:0]  ci;
  } vec_t;

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", nm, got, exp);
    end
  endtask

  // One operation; after the start edge the inputs are scrambled and start kept high to prove they are ignored.
  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                       output int lat, output logic [3:0] ci_seen, output logic [31:0] r,
                       output logic co, output logic ov, output logic z,
                       output logic done_after, output logic [31:0] r_after);
    start = 1'b1; op_a = a; op_b = b; sub = s;
    @(posedge clk); #1;
    op_a = ~a; op_b = b ^ 32'h5a5a_5a5a; sub = ~s;
    lat = 1;
    ci_seen = '0;
    while (!done && lat < 20) begin
      if (lat <= 4) ci_seen[lat-1] = add_ci;
      if (lat == 3) start = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    start = 1'b0;
    r = result; co = carry_out; ov = overflow; z = zero;
    @(posedge clk); #1;
    done_after = done;
    r_after = result;
  endtask

  vec_t vecs[8];

  initial begin
    int          lat;
    logic [3:0]  ci_seen;
    logic [31:0] r, r_after;
    logic        co, ov, z, done_after;
    int          cnt, d1, d2;
    logic        seen_done;

    vecs[0] = '{32'h1234_5678, 32'h1111_1111, 1'b0, 32'h2345_6789, 1'b0, 1'b0, 1'b0, 4'b0000};
    vecs[1] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 4'b1110};
    vecs[2] = '{32'h0000_0005, 32'h0000_0007, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0, 4'b0001};
    vecs[3] = '{32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0, 4'b0001};
    vecs[4] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0, 4'b1110};
    vecs[5] = '{32'h0000_0007, 32'h0000_0007, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 4'b1111};
    vecs[6] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b1, 4'b0000};
    vecs[7] = '{32'h0000_FF00, 32'h0000_0100, 1'b0, 32'h0001_0000, 1'b0, 1'b0, 1'b0, 4'b0100};

    rst_n = 1'b0; start = 1'b0; sub = 1'b0; cin_use = 1'b0; op_a = '0; op_b = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_result", 64'(result), 64'h0);
    check("reset_ctrl", 64'({busy, done, carry_out, overflow, zero, add_ci}), 64'h0);
    check("reset_slice_ops", 64'({add_a, add_b}), 64'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("idle_slice_ops", 64'({add_a, add_b, add_ci}), 64'h0);

    for (int i = 0; i < 8; i++) begin
      do_op(vecs[i].a, vecs[i].b, vecs[i].s, lat, ci_seen, r, co, ov, z, done_after, r_after);
      check($sformatf("v%0d_latency", i), 64'(lat), 64'd5);
      check($sformatf("v%0d_result", i), 64'(r), 64'(vecs[i].res));
      check($sformatf("v%0d_carry_out", i), 64'(co), 64'(vecs[i].co));
      check($sformatf("v%0d_overflow", i), 64'(ov), 64'(vecs[i].ov));
      check($sformatf("v%0d_zero", i), 64'(z), 64'(vecs[i].z));
      check($sformatf("v%0d_add_ci_steps", i), 64'(ci_seen), 64'(vecs[i].ci));
      check($sformatf("v%0d_done_pulse", i), 64'(done_after), 64'h0);
      check($sformatf("v%0d_result_held", i), 64'(r_after), 64'(vecs[i].res));
    end

    // start held high: one accept per six cycles
    start = 1'b1; op_a = 32'h0000_0010; op_b = 32'h0000_0020; sub = 1'b0;
    cnt = 0; d1 = 0; d2 = 0;
    for (int k = 1; k <= 13; k++) begin
      @(posedge clk); #1;
      if (done) begin
        cnt++;
        if (cnt == 1) d1 = k;
        else if (cnt == 2) d2 = k;
        check($sformatf("hold_result_k%0d", k), 64'(result), 64'h30);
      end
      if (k == 6) check("hold_idle_gap_busy", 64'(busy), 64'h0);
    end
    start = 1'b0;
    check("hold_done_count", 64'(cnt), 64'd2);
    check("hold_first_done", 64'(d1), 64'd5);
    check("hold_second_done", 64'(d2), 64'd11);
    for (int k = 0; k < 10 && busy; k++) begin
      @(posedge clk); #1;
    end
    check("hold_drained", 64'(busy), 64'h0);

    // Reset in RUN step 2 after an op that left all flags set
    do_op(32'h8000_0000, 32'h8000_0000, 1'b0, lat, ci_seen, r, co, ov, z, done_after, r_after);
    start = 1'b1; op_a = 32'h1234_5678; op_b = 32'h1111_1111; sub = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("abort_in_run", 64'(busy), 64'h1);
    rst_n = 1'b0;
    #1;
    check("abort_result", 64'(result), 64'h0);
    check("abort_ctrl", 64'({busy, done, carry_out, overflow, zero, add_ci}), 64'h0);
    check("abort_slice_ops", 64'({add_a, add_b}), 64'h0);
    #1;
    rst_n = 1'b1;
    seen_done = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      if (done || busy) seen_done = 1'b1;
    end
    check("abort_no_done", 64'(seen_done), 64'h0);
    do_op(32'h1234_5678, 32'h1111_1111, 1'b0, lat, ci_seen, r, co, ov, z, done_after, r_after);
    check("recover_latency", 64'(lat), 64'd5);
    check("recover_result", 64'(r), 64'h2345_6789);

`ifdef ALU_BYTE_SERIAL_ADC_EN
    cin_use = 1'b0;
    do_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, lat, ci_seen, r, co, ov, z, done_after, r_after);
    check("adc_first_carry", 64'(co), 64'h1);
    cin_use = 1'b1;
    do_op(32'h0, 32'h0, 1'b0, lat, ci_seen, r, co, ov, z, done_after, r_after);
    cin_use = 1'b0;
    check("adc_second_result", 64'(r), 64'h1);
    check("adc_second_carry", 64'(co), 64'h0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_byte_serial_adder.md
Name: alu_byte_serial_adder

Overview:
- Sequencer sitting directly upstream of the 8-bit ALU adder slice.
- Breaks a WIDTH-bit add/subtract into byte steps and feeds one byte pair per cycle to the slice.
- Consumes the slice's 9-bit sum, chaining bit 8 as carry into the next byte.
- Presents the assembled result and flags to the processor datapath with a start/done handshake.

Parameters:
- WIDTH, 32: operand and result width; must be a multiple of SLICE.
- SLICE, 8: adder slice width.
- NSTEP, WIDTH/SLICE: derived; number of byte steps (4).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request; sampled only in IDLE
- sub  in  1  1 = A-B (B inverted, initial carry 1); 0 = A+B
- op_a  in  WIDTH  operand A
- op_b  in  WIDTH  operand B
- busy  out  1  high in RUN and DONE
- done  out  1  one-cycle pulse; result and flags valid from this cycle
- result  out  WIDTH  sum/difference, registered
- carry_out  out  1  carry from MSB (for sub: 1 = no borrow)
- overflow  out  1  signed overflow
- zero  out  1  result == 0
- add_a  out  9  to slice A: {1'b0, byte of A}
- add_b  out  9  to slice B: {1'b0, byte of B or ~B}
- add_ci  out  1  to slice CI: chained carry
- add_sum  in  9  from slice; contract: add_sum = add_a + add_b + add_ci, combinational

Behaviour:
- Reset (async, rst_n low): state IDLE, step=0, busy=0, done=0, result=0, carry_out=0, overflow=0, zero=0, carry reg=0.
- add_a, add_b and add_ci are 0 whenever the state is not RUN.
- IDLE:
  - On start=1, latch op_a, (sub ? ~op_b : op_b), carry reg <= sub, step <= 0.
  - Go to RUN.
- RUN:
  - Present byte[step] of the latched operands and add_ci = carry reg.
  - At the clock edge: result byte[step] <= add_sum[7:0]; carry reg <= add_sum[8]; step++.
  - When step == NSTEP-1, go to DONE.
- DONE:
  - done=1 for exactly one cycle, then return to IDLE.
  - carry_out = final carry reg.
  - overflow = (a[W-1] == b'[W-1]) && (result[W-1] != a[W-1]), where b' is the latched possibly inverted B.
  - zero = ~|result.
  - Flags are registered on the DONE entry edge and held until the next start.
- Latency:
  - start sampled at edge 0.
  - RUN occupies NSTEP cycles.
  - done is high in cycle NSTEP+1 (5 for defaults).
  - Back-to-back: start may be asserted in the DONE cycle but is ignored; it is accepted in the following IDLE cycle.
- start while busy: ignored, no effect on latched operands.
- op_a, op_b and sub may change freely after the start edge.
- result holds partially updated bytes during RUN; consumers use it only at or after done.
- Reset mid-RUN: immediate abort to IDLE with all outputs cleared; no done is issued.
- Arithmetic wraps modulo 2^WIDTH: 0xFFFFFFFF + 1 = 0x00000000 with carry_out=1.

Optional Feature:
- Macro: ALU_BYTE_SERIAL_ADC_EN.
- With the macro defined:
  - Extra input port `cin_use` (1 bit) is present.
  - On start with cin_use=1, the initial carry reg is loaded with the carry_out of the previous operation instead of sub, enabling add-with-carry and subtract-with-borrow chains.
  - The previous carry_out is cleared by reset.
- Without the macro: no cin_use port; the initial carry is always sub.

Decomposition:
- Package alu_seq_pkg holds:
  - State enum: IDLE, RUN, DONE.
  - Constants SLICE_W=8 and SUM_W=9.
  - Function `byte_sel(vec, idx)`.
- One natural sub-module: alu_seq_flags, a combinational block computing zero and overflow from result, latched A MSB and latched B MSB.
- The adder slice stays external; the bench uses a behavioural 9-bit model of it.

Test Plan:
- Plain add:
  - Stimulus: A=0x12345678, B=0x11111111, sub=0.
  - Required: done at cycle 5; result=0x23456789; carry_out=0; overflow=0; zero=0.
- Full carry ripple:
  - Stimulus: A=0xFFFFFFFF, B=0x00000001, sub=0.
  - Required: result=0x00000000; carry_out=1; zero=1; overflow=0; add_ci=1 in RUN steps 1–3.
- Subtract:
  - Stimulus 1: A=5, B=7, sub=1. Required: result=0xFFFFFFFE; carry_out=0; overflow=0.
  - Stimulus 2: A=0x80000000, B=1, sub=1. Required: result=0x7FFFFFFF; overflow=1.
- Signed overflow add:
  - Stimulus: A=0x7FFFFFFF, B=1, sub=0.
  - Required: result=0x80000000; overflow=1; carry_out=0.
- Control edge cases:
  - Stimulus 1: start held high continuously. Required: accepted once per 6-cycle period (start, 4 RUN, DONE, then IDLE accept).
  - Stimulus 2: change op_a during RUN. Required: result unaffected.
  - Stimulus 3: rst_n pulsed low in RUN step 2. Required: all outputs 0 immediately; no done pulse.
- ADC (ALU_BYTE_SERIAL_ADC_EN only):
  - Stimulus: 0xFFFFFFFF+1, then 0+0 with cin_use=1.
  - Required: second result=0x00000001.
